// File: rtl/line_sum_generator_if.sv
// ============================================================================
// Module      : line_sum_generator_if
// Description : Pixel-in / line-sum-out bundle for line_sum_generator.
//               Parameter names follow the project Parameters.svh set
//               (PIXEL_SIZE, LINE_SIZE, NUM_TEMPLATES, NUM_OF_LINES).
// Signals     : pix_valid, pix_in, tmpl_pix              (master -> slave)
//               I_square_out_line_sum, I_out_line_sum,
//               T_x_I_out_lines_sum, line_valid,
//               line_idx, frame_done                      (slave -> master)
// Modports    : master (pixel source / sum sink), slave (the generator)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface line_sum_generator_if #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 4,
    parameter int NUM_TEMPLATES = 2,
    parameter int NUM_OF_LINES  = 3
);
    localparam int SW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
    localparam int LW = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1;

    logic                                     pix_valid;
    logic [PIXEL_SIZE-1:0]                    pix_in;
    logic [NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] tmpl_pix;

    logic [SW-1:0]                            I_square_out_line_sum;
    logic [SW-1:0]                            I_out_line_sum;
    logic [NUM_TEMPLATES-1:0][SW-1:0]         T_x_I_out_lines_sum;
    logic                                     line_valid;
    logic [LW-1:0]                            line_idx;
    logic                                     frame_done;

    modport master (
        output pix_valid, pix_in, tmpl_pix,
        input  I_square_out_line_sum, I_out_line_sum, T_x_I_out_lines_sum,
               line_valid, line_idx, frame_done
    );

    modport slave (
        input  pix_valid, pix_in, tmpl_pix,
        output I_square_out_line_sum, I_out_line_sum, T_x_I_out_lines_sum,
               line_valid, line_idx, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/line_sum_generator.sv
// ============================================================================
// Module      : line_sum_generator
// Description : Two-stage pipeline producing per-line sums of I, I*I and
//               T*I (one per template).  Stage 1 registers the products of
//               each valid pixel; stage 2 accumulates them and publishes a
//               complete line with a one-cycle line_valid pulse.
//               Optional macro LSG_FRAME_CNT_EN enables the line counter
//               (line_idx, frame_done); without it both are tied to 0.
// Ports       : CLK   - clock, rising edge
//               reset - synchronous, active-low
//               bus   - line_sum_generator_if.slave (pixels in, sums out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_sum_generator #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 4,
    parameter int NUM_TEMPLATES = 2,
    parameter int NUM_OF_LINES  = 3
) (
    input  wire logic            CLK,
    input  wire logic            reset,
    line_sum_generator_if.slave  bus
);
    localparam int SW = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
    localparam int P2 = 2 * PIXEL_SIZE;
    localparam int CW = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
    localparam int LW = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1;
    localparam logic [CW-1:0] C_LAST_COL  = CW'(LINE_SIZE - 1);
    localparam logic [LW-1:0] C_LAST_LINE = LW'(NUM_OF_LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Stage 1: registered pixel and products
    logic                            s1_valid_q;
    logic [PIXEL_SIZE-1:0]           s1_i_q;
    logic [P2-1:0]                   s1_isq_q;
    logic [NUM_TEMPLATES-1:0][P2-1:0] s1_txi_q;

    // Stage 2: running accumulators and published line sums
    logic [CW-1:0]                   col_q;
    logic [SW-1:0]                   acc_i_q, acc_isq_q;
    logic [NUM_TEMPLATES-1:0][SW-1:0] acc_txi_q;
    logic [SW-1:0]                   out_i_q, out_isq_q;
    logic [NUM_TEMPLATES-1:0][SW-1:0] out_txi_q;

    logic                            w_last;
    logic                            w_fresh;
    logic [SW-1:0]                   w_sum_i, w_sum_isq;
    logic [NUM_TEMPLATES-1:0][SW-1:0] w_sum_txi;
    logic [P2-1:0]                   w_pix_ext;
    logic [NUM_TEMPLATES-1:0][P2-1:0] w_txi;

    // Stage-1 products, computed at full 2*PIXEL_SIZE width (unsigned)
    always_comb begin
        w_pix_ext = P2'(bus.pix_in);
        w_txi     = '0;
        for (int t = 0; t < NUM_TEMPLATES; t++) begin
            w_txi[t] = P2'(bus.tmpl_pix[t]) * w_pix_ext;
        end
    end

    // FSM next state and the stage-2 adder.  Outside ACCUM the accumulator
    // is loaded rather than added, so a pixel arriving in the EMIT cycle
    // begins the next line cleanly.
    always_comb begin
        state_d   = state_q;
        w_last    = s1_valid_q && (col_q == C_LAST_COL);
        w_fresh   = (state_q != S_ACCUM);
        w_sum_i   = w_fresh ? SW'(s1_i_q)   : acc_i_q   + SW'(s1_i_q);
        w_sum_isq = w_fresh ? SW'(s1_isq_q) : acc_isq_q + SW'(s1_isq_q);
        w_sum_txi = '0;
        for (int t = 0; t < NUM_TEMPLATES; t++) begin
            w_sum_txi[t] = w_fresh ? SW'(s1_txi_q[t])
                                   : acc_txi_q[t] + SW'(s1_txi_q[t]);
        end

        case (state_q)
            S_IDLE: begin
                if (s1_valid_q) state_d = w_last ? S_EMIT : S_ACCUM;
            end
            S_ACCUM: begin
                if (w_last) state_d = S_EMIT;
            end
            S_EMIT: begin
                if (s1_valid_q) state_d = w_last ? S_EMIT : S_ACCUM;
                else            state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_i_q     <= '0;
            s1_isq_q   <= '0;
            s1_txi_q   <= '0;
            col_q      <= '0;
            acc_i_q    <= '0;
            acc_isq_q  <= '0;
            acc_txi_q  <= '0;
            out_i_q    <= '0;
            out_isq_q  <= '0;
            out_txi_q  <= '0;
        end else begin
            s1_valid_q <= bus.pix_valid;
            if (bus.pix_valid) begin
                s1_i_q   <= bus.pix_in;
                s1_isq_q <= w_pix_ext * w_pix_ext;
                s1_txi_q <= w_txi;
            end

            if (s1_valid_q) begin
                col_q <= w_last ? '0 : col_q + 1'b1;
                if (w_last) begin
                    // Final sum goes straight to the outputs; the
                    // accumulator is reloaded by the next line's first pixel.
                    out_i_q   <= w_sum_i;
                    out_isq_q <= w_sum_isq;
                    out_txi_q <= w_sum_txi;
                end else begin
                    acc_i_q   <= w_sum_i;
                    acc_isq_q <= w_sum_isq;
                    acc_txi_q <= w_sum_txi;
                end
            end
        end
    end

    assign bus.I_out_line_sum        = out_i_q;
    assign bus.I_square_out_line_sum = out_isq_q;
    assign bus.T_x_I_out_lines_sum   = out_txi_q;
    assign bus.line_valid            = (state_q == S_EMIT);

`ifdef LSG_FRAME_CNT_EN
    logic [LW-1:0] line_cnt_q;

    // Advances at the end of each EMIT cycle, so line_idx names the line
    // currently being presented.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            line_cnt_q <= '0;
        end else if (state_q == S_EMIT) begin
            line_cnt_q <= (line_cnt_q == C_LAST_LINE) ? '0 : line_cnt_q + 1'b1;
        end
    end

    assign bus.line_idx   = line_cnt_q;
    assign bus.frame_done = (state_q == S_EMIT) && (line_cnt_q == C_LAST_LINE);
`else
    assign bus.line_idx   = '0;
    assign bus.frame_done = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_sum_generator.sv
// ============================================================================
// Module      : tb_line_sum_generator
// Description : Self-checking bench for line_sum_generator.  A queue-based
//               reference model collects accepted pixels per line, computes
//               the sums arithmetically and schedules when each line must
//               appear; directed cases are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_sum_generator;
    localparam int PS = 8;
    localparam int LS = 4;
    localparam int NT = 2;
    localparam int NL = 3;

`ifdef LSG_FRAME_CNT_EN
    localparam bit FCNT = 1'b1;
`else
    localparam bit FCNT = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic reset = 1'b0;

    always #5 CLK = ~CLK;

    line_sum_generator_if #(
        .PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT), .NUM_OF_LINES(NL)
    ) bus ();

    line_sum_generator #(
        .PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT), .NUM_OF_LINES(NL)
    ) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        int i;
        int t0;
        int t1;
    } pix_t;

    typedef struct packed {
        int     due;
        longint isum;
        longint isq;
        longint txi0;
        longint txi1;
        int     idx;
        bit     fd;
    } exp_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    bit     started  = 1'b0;

    pix_t   line_q[$];
    exp_t   exp_q[$];
    int     m_line   = 0;
    longint last_isum = 0, last_isq = 0, last_txi0 = 0, last_txi1 = 0;

    // Captured DUT values at the most recent line_valid pulse
    longint obs_isum = 0, obs_isq = 0, obs_txi0 = 0, obs_txi1 = 0;
    int     obs_idx  = 0;
    int     n_lines  = 0;
    int     n_fd     = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: a line is the next LS accepted pixels; its sums
    // must be visible two cycles after the cycle its last pixel was driven.
    always @(posedge CLK) begin
        pix_t   p;
        exp_t   e;
        if (!reset) begin
            line_q.delete();
            exp_q.delete();
            m_line    = 0;
            last_isum = 0;
            last_isq  = 0;
            last_txi0 = 0;
            last_txi1 = 0;
            started   = 1'b1;
        end else if (bus.pix_valid) begin
            p.i  = int'(bus.pix_in);
            p.t0 = int'(bus.tmpl_pix[0]);
            p.t1 = int'(bus.tmpl_pix[1]);
            line_q.push_back(p);
            if (line_q.size() == LS) begin
                e = '0;
                foreach (line_q[k]) begin
                    e.isum += line_q[k].i;
                    e.isq  += line_q[k].i * line_q[k].i;
                    e.txi0 += line_q[k].t0 * line_q[k].i;
                    e.txi1 += line_q[k].t1 * line_q[k].i;
                end
                e.due = cyc + 2;
                e.idx = FCNT ? m_line : 0;
                e.fd  = FCNT && (m_line == NL - 1);
                exp_q.push_back(e);
                m_line = (m_line + 1) % NL;
                line_q.delete();
            end
        end
        cyc++;
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        exp_t e;
        bit   exp_lv;
        if (started) begin
            exp_lv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check_val("line_valid", longint'(bus.line_valid), longint'(exp_lv));
            if (bus.frame_done) n_fd++;
            if (bus.line_valid) begin
                n_lines++;
                obs_isum = longint'(bus.I_out_line_sum);
                obs_isq  = longint'(bus.I_square_out_line_sum);
                obs_txi0 = longint'(bus.T_x_I_out_lines_sum[0]);
                obs_txi1 = longint'(bus.T_x_I_out_lines_sum[1]);
                obs_idx  = int'(bus.line_idx);
            end
            if (exp_lv) begin
                e = exp_q.pop_front();
                last_isum = e.isum;
                last_isq  = e.isq;
                last_txi0 = e.txi0;
                last_txi1 = e.txi1;
                check_val("line_idx",   longint'(bus.line_idx),   longint'(e.idx));
                check_val("frame_done", longint'(bus.frame_done), longint'(e.fd));
            end else begin
                check_val("frame_done_idle", longint'(bus.frame_done), 0);
            end
            check_val("I_sum",  longint'(bus.I_out_line_sum),          last_isum);
            check_val("I_sq",   longint'(bus.I_square_out_line_sum),   last_isq);
            check_val("TxI0",   longint'(bus.T_x_I_out_lines_sum[0]),  last_txi0);
            check_val("TxI1",   longint'(bus.T_x_I_out_lines_sum[1]),  last_txi1);
        end
    end

    task automatic send(input bit v, input int i, input int t0, input int t1);
        @(posedge CLK);
        #1;
        bus.pix_valid   = v;
        bus.pix_in      = PS'(i);
        bus.tmpl_pix[0] = PS'(t0);
        bus.tmpl_pix[1] = PS'(t1);
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) send(1'b0, $urandom_range(0, 255), 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        bus.pix_valid = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        reset = 1'b1;
        bus.pix_valid = 1'b0;
    endtask

    task automatic drain;
        int budget;
        send(1'b0, 0, 0, 0);
        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        check_val("drain_timeout", longint'(exp_q.size()), 0);
        bubble(2);
    endtask

    initial begin
        int base;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        bus.tmpl_pix  = '0;
        reset         = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        reset = 1'b1;

        // Basic line
        for (int k = 1; k <= 4; k++) send(1'b1, k, 1, 2);
        drain();
        check_val("d1_isum", obs_isum, 10);
        check_val("d1_isq",  obs_isq,  30);
        check_val("d1_txi0", obs_txi0, 10);
        check_val("d1_txi1", obs_txi1, 20);

        // Full-scale pixels
        for (int k = 0; k < 4; k++) send(1'b1, 255, 255, 255);
        drain();
        check_val("d2_isum", obs_isum, 1020);
        check_val("d2_isq",  obs_isq,  260100);
        check_val("d2_txi0", obs_txi0, 260100);
        check_val("d2_txi1", obs_txi1, 260100);

        // Bubbles between pixels
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, k, 1, 2);
            bubble(1);
        end
        drain();
        check_val("d3_isum", obs_isum, 10);
        check_val("d3_isq",  obs_isq,  30);
        check_val("d3_txi1", obs_txi1, 20);

        // One frame of back-to-back lines
        do_reset(2);
        base = n_lines;
        n_fd = 0;
        for (int l = 0; l < 3; l++)
            for (int k = 1; k <= 4; k++) send(1'b1, k, 1, 2);
        drain();
        check_val("d4_lines", longint'(n_lines - base), 3);
        check_val("d4_isum",  obs_isum, 10);
        check_val("d4_idx",   longint'(obs_idx), FCNT ? 2 : 0);
        check_val("d4_fd",    longint'(n_fd),    FCNT ? 1 : 0);

        // Reset in mid-line discards the partial line
        send(1'b1, 9, 3, 3);
        send(1'b1, 9, 3, 3);
        do_reset(1);
        base = n_lines;
        for (int k = 0; k < 4; k++) send(1'b1, 5, 1, 1);
        drain();
        check_val("d5_lines", longint'(n_lines - base), 1);
        check_val("d5_isum",  obs_isum, 20);
        check_val("d5_idx",   longint'(obs_idx), 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                send($urandom_range(0, 3) != 0, $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255));
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/line_sum_generator.md
LINE_SUM_GENERATOR -- requirements
Module: line_sum_generator

Interface
REQ-001 Parameters SHALL come from Parameters.svh: PIXEL_SIZE (bits per pixel), LINE_SIZE (pixels per line), NUM_TEMPLATES (parallel templates), NUM_OF_LINES (lines per frame).
REQ-002 Derived width SW = $clog2(LINE_SIZE)+2*PIXEL_SIZE SHALL be used for every line-sum output.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low; sampled on CLK rising edge.
REQ-005 pix_valid  input  1  pix_in and tmpl_pix qualified this cycle.
REQ-006 pix_in  input  PIXEL_SIZE  image pixel I.
REQ-007 tmpl_pix  input  [NUM_TEMPLATES] x PIXEL_SIZE  template pixel T per template, same column as pix_in.
REQ-008 I_square_out_line_sum  output  SW  sum of I*I over one line.
REQ-009 I_out_line_sum  output  SW  sum of I over one line.
REQ-010 T_x_I_out_lines_sum  output  [NUM_TEMPLATES] x SW  sum of T*I per template over one line.
REQ-011 line_valid  output  1  one-cycle pulse; the three sum outputs are a complete line.
REQ-012 line_idx  output  $clog2(NUM_OF_LINES)  index of the line presented with line_valid.
REQ-013 frame_done  output  1  one-cycle pulse coincident with line_valid of the last frame line.

Function
REQ-014 Stage 1 SHALL register I, I*I and T*I per template (2*PIXEL_SIZE bits, unsigned) plus a valid bit for every cycle pix_valid=1.
REQ-015 Stage 2 SHALL add stage-1 values into SW-bit accumulators; no saturation or truncation; widths are sufficient by construction.
REQ-016 FSM states: IDLE (no pixel of current line received), ACCUM (1..LINE_SIZE-1 pixels received), EMIT (line complete, outputs updated).
REQ-017 IDLE->ACCUM on first stage-1 valid; ACCUM->EMIT when the LINE_SIZE-th stage-1 valid is added; EMIT->IDLE next cycle, or EMIT->ACCUM if a stage-1 valid is present that cycle.
REQ-018 Column counter SHALL increment per stage-1 valid and wrap from LINE_SIZE-1 to 0.
REQ-019 Latency: LINE_SIZE-th pixel accepted at cycle N -> line_valid=1 at cycle N+2 with final sums.
REQ-020 Sum outputs SHALL hold the last completed line between line_valid pulses.
REQ-021 Cycles with pix_valid=0 (bubbles) SHALL leave accumulators, counters and FSM unchanged.
REQ-022 Back-to-back lines with no bubble SHALL be lossless: first pixel of line k+1 starts a fresh accumulation (accumulator loaded, not added) in the cycle line k is emitted.
REQ-023 line_idx SHALL increment after each line_valid and wrap NUM_OF_LINES-1 -> 0.

Reset
REQ-024 While reset=0 all outputs SHALL be 0, FSM IDLE, column and line counters 0, pipeline valid bits cleared.
REQ-025 reset=0 mid-line SHALL discard the partial line; the first valid pixel after reset release is column 0 of line 0.
REQ-026 Pixels presented while reset=0 SHALL be ignored.

Configuration
REQ-027 Macro LSG_FRAME_CNT_EN defined: line counter, line_idx and frame_done behave per REQ-012/013/023.
REQ-028 Macro LSG_FRAME_CNT_EN undefined: line counter not instantiated; line_idx and frame_done tied to 0; sum and line_valid behaviour unchanged.

Verification (PIXEL_SIZE=8, LINE_SIZE=4, NUM_TEMPLATES=2, NUM_OF_LINES=3)
REQ-029 I=1,2,3,4, T0=1 each, T1=2 each, consecutive -> line_valid 2 cycles after pixel 4; I_sum=10, I_sq=30, TxI=[10,20].
REQ-030 I=255 x4, T=255 both -> I_sum=1020, I_sq=260100, TxI=[260100,260100], no wrap in 10-bit/18-bit fields.
REQ-031 Same pixels as REQ-029 with pix_valid=0 bubble between each -> identical sums; line_valid 2 cycles after last accepted pixel.
REQ-032 3 lines back-to-back (I=1,2,3,4 each) -> three line_valid pulses 4 cycles apart, each I_sum=10, line_idx 0,1,2, frame_done only with line 2 (macro on; 0 with macro off).
REQ-033 reset=0 after 2 pixels, release, then 4 pixels I=5 -> single line_valid, I_sum=20, line_idx=0.
